// File: rtl/axi_pkg.sv
// Shared AXI definitions for the crossbar channel blocks: RRESP encodings,
// default widths and the R-channel burst tracker states.
package axi_pkg;

  localparam int unsigned IdWidth      = 4;
  localparam int unsigned DataWidth    = 32;
  localparam int unsigned PendingDepth = 4;
  localparam int unsigned BeatCntWidth = 8;

  typedef enum logic [1:0] {
    RespOkay   = 2'b00,
    RespExokay = 2'b01,
    RespSlverr = 2'b10,
    RespDecerr = 2'b11
  } resp_e;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StBurst = 1'b1
  } burst_state_e;

endpackage

// File: rtl/r_ring_buffer.sv
// Ring buffer with wrap-bit pointers; every entry is usable. The read side is
// first-word-fall-through with no write-to-read bypass.
module r_ring_buffer #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [Width-1:0]         wdata_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   occupancy_o
);

  localparam int unsigned IdxWidth = $clog2(Depth);
  localparam int unsigned PtrWidth = IdxWidth + 1;

  logic [Width-1:0]    mem_q [Depth];
  logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PtrWidth'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PtrWidth'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q[IdxWidth-1:0]] <= wdata_i;
  end

  assign rdata_o     = mem_q[rd_ptr_q[IdxWidth-1:0]];
  assign empty_o     = (wr_ptr_q == rd_ptr_q);
  assign full_o      = (wr_ptr_q[IdxWidth-1:0] == rd_ptr_q[IdxWidth-1:0]) &&
                       (wr_ptr_q[PtrWidth-1] != rd_ptr_q[PtrWidth-1]);
  assign occupancy_o = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/r_resp_buffer.sv
// R-channel response buffer: stores slave beats, presents them FWFT to the
// master, and tracks burst progress so the arbiter can hold its grant.
module r_resp_buffer
  import axi_pkg::*;
#(
  parameter int unsigned ID_WIDTH       = IdWidth,
  parameter int unsigned DATA_WIDTH     = DataWidth,
  parameter int unsigned pending_depth  = PendingDepth,
  parameter int unsigned BEAT_CNT_WIDTH = BeatCntWidth
) (
  input  logic                            ACLK,
  input  logic                            ARESETn,
  input  logic [ID_WIDTH-1:0]             S_RID,
  input  logic [DATA_WIDTH-1:0]           S_RDATA,
  input  logic [1:0]                      S_RRESP,
  input  logic                            S_RLAST,
  input  logic                            S_RVALID,
  output logic                            S_RREADY,
  output logic [ID_WIDTH-1:0]             M_RID,
  output logic [DATA_WIDTH-1:0]           M_RDATA,
  output logic [1:0]                      M_RRESP,
  output logic                            M_RLAST,
  output logic                            M_RVALID,
  input  logic                            M_RREADY,
  output logic                            burst_active,
  output logic [BEAT_CNT_WIDTH-1:0]       beat_cnt,
  output logic                            burst_done,
  output logic [$clog2(pending_depth):0]  occupancy
);

  localparam int unsigned EntryWidth = ID_WIDTH + DATA_WIDTH + 3;

  logic                  full, empty, push, pop;
  logic [EntryWidth-1:0] wr_entry, rd_entry;

  // Ready/valid are gated by reset so nothing moves while ARESETn is low.
  assign S_RREADY = ~full & ARESETn;
  assign M_RVALID = ~empty & ARESETn;
  assign push     = S_RVALID & S_RREADY;
  assign pop      = M_RVALID & M_RREADY;

  assign wr_entry = {S_RID, S_RDATA, S_RRESP, S_RLAST};
  assign {M_RID, M_RDATA, M_RRESP, M_RLAST} = rd_entry;

  r_ring_buffer #(
    .Width (EntryWidth),
    .Depth (pending_depth)
  ) u_ring (
    .clk_i       (ACLK),
    .rst_ni      (ARESETn),
    .push_i      (push),
    .pop_i       (pop),
    .wdata_i     (wr_entry),
    .rdata_o     (rd_entry),
    .full_o      (full),
    .empty_o     (empty),
    .occupancy_o (occupancy)
  );

  burst_state_e              state_q, state_d;
  logic [BEAT_CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic                      burst_done_q, burst_done_d;

  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    burst_done_d = 1'b0;
    if (pop) begin
      if (M_RLAST) begin
        state_d      = StIdle;
        beat_cnt_d   = '0;
        burst_done_d = 1'b1;
      end else begin
        unique case (state_q)
          StIdle: begin
            state_d    = StBurst;
            beat_cnt_d = BEAT_CNT_WIDTH'(1);
          end
          StBurst: begin
            if (beat_cnt_q != '1) beat_cnt_d = beat_cnt_q + BEAT_CNT_WIDTH'(1);
          end
          default: state_d = StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q      <= StIdle;
      beat_cnt_q   <= '0;
      burst_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      burst_done_q <= burst_done_d;
    end
  end

  assign burst_active = (state_q == StBurst);
  assign beat_cnt     = beat_cnt_q;
  assign burst_done   = burst_done_q;

endmodule

// File: tb/tb_r_resp_buffer.sv
// Self-checking bench for r_resp_buffer: directed scenarios plus a random
// phase, all checked against a queue-based model of the buffer and burst rules.
module tb_r_resp_buffer;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic [3:0]  S_RID = '0;
  logic [31:0] S_RDATA = '0;
  logic [1:0]  S_RRESP = '0;
  logic        S_RLAST = 1'b0;
  logic        S_RVALID = 1'b0;
  logic        S_RREADY;
  logic [3:0]  M_RID;
  logic [31:0] M_RDATA;
  logic [1:0]  M_RRESP;
  logic        M_RLAST;
  logic        M_RVALID;
  logic        M_RREADY = 1'b0;
  logic        burst_active;
  logic [7:0]  beat_cnt;
  logic        burst_done;
  logic [2:0]  occupancy;

  r_resp_buffer #(
    .ID_WIDTH       (4),
    .DATA_WIDTH     (32),
    .pending_depth  (DEPTH),
    .BEAT_CNT_WIDTH (8)
  ) dut (
    .ACLK         (ACLK),
    .ARESETn      (ARESETn),
    .S_RID        (S_RID),
    .S_RDATA      (S_RDATA),
    .S_RRESP      (S_RRESP),
    .S_RLAST      (S_RLAST),
    .S_RVALID     (S_RVALID),
    .S_RREADY     (S_RREADY),
    .M_RID        (M_RID),
    .M_RDATA      (M_RDATA),
    .M_RRESP      (M_RRESP),
    .M_RLAST      (M_RLAST),
    .M_RVALID     (M_RVALID),
    .M_RREADY     (M_RREADY),
    .burst_active (burst_active),
    .beat_cnt     (beat_cnt),
    .burst_done   (burst_done),
    .occupancy    (occupancy)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO contents and burst bookkeeping.
  beat_t mq[$];
  bit    m_active = 0;
  int    m_cnt    = 0;
  bit    m_done   = 0;

  function automatic beat_t mk(input logic [3:0] id, input logic [31:0] data,
                               input logic [1:0] resp, input logic last);
    beat_t b;
    b.id = id; b.data = data; b.resp = resp; b.last = last;
    return b;
  endfunction

  function automatic beat_t head_obs();
    beat_t b;
    b.id = M_RID; b.data = M_RDATA; b.resp = M_RRESP; b.last = M_RLAST;
    return b;
  endfunction

  // Drive one cycle from a negedge, advance the model at the posedge.
  task automatic tick(input beat_t b, input bit sv, input bit mr);
    bit    do_push, do_pop;
    beat_t h;
    S_RID = b.id; S_RDATA = b.data; S_RRESP = b.resp; S_RLAST = b.last;
    S_RVALID = sv; M_RREADY = mr;
    do_push = sv && (mq.size() < DEPTH);
    do_pop  = mr && (mq.size() > 0);
    @(posedge ACLK);
    m_done = 0;
    if (do_pop) begin
      h = mq.pop_front();
      if (h.last) begin
        m_active = 0; m_cnt = 0; m_done = 1;
      end else begin
        m_active = 1;
        if (m_cnt < 255) m_cnt++;
      end
    end
    if (do_push) mq.push_back(b);
    @(negedge ACLK);
  endtask

  task automatic reset_tick();
    ARESETn = 1'b0; S_RVALID = 1'b0; M_RREADY = 1'b0;
    @(posedge ACLK);
    mq.delete(); m_active = 0; m_cnt = 0; m_done = 0;
    @(negedge ACLK);
  endtask

  task automatic test_reset();
    @(negedge ACLK);
    reset_tick();
    checks++;
    if (S_RREADY !== 1'b0 || M_RVALID !== 1'b0) begin
      errors++;
      $display("FAIL reset_low_handshake: rdy=%b vld=%b required 0 0", S_RREADY, M_RVALID);
    end
    reset_tick();
    ARESETn = 1'b1;
    #1;
    checks++;
    if (S_RREADY !== 1'b1 || M_RVALID !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: rdy=%b vld=%b required 1 0", S_RREADY, M_RVALID);
    end
    checks++;
    if (occupancy !== 3'd0 || beat_cnt !== 8'd0 || burst_active !== 1'b0 || burst_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: occ=%0d cnt=%0d act=%b done=%b required 0 0 0 0",
               occupancy, beat_cnt, burst_active, burst_done);
    end
  endtask

  task automatic test_single();
    beat_t b;
    b = mk(4'd3, 32'hA5A5_0001, 2'b00, 1'b1);
    tick(b, 1, 0);
    checks++;
    if (M_RVALID !== 1'b1 || head_obs() !== b) begin
      errors++;
      $display("FAIL single_head: vld=%b head=%h required 1 %h", M_RVALID, head_obs(), b);
    end
    tick(b, 0, 1);
    checks++;
    if (burst_done !== 1'b1 || occupancy !== 3'd0 || M_RVALID !== 1'b0) begin
      errors++;
      $display("FAIL single_pop: done=%b occ=%0d vld=%b required 1 0 0",
               burst_done, occupancy, M_RVALID);
    end
    tick(b, 0, 1);
    checks++;
    if (burst_done !== 1'b0 || burst_active !== 1'b0) begin
      errors++;
      $display("FAIL single_done_pulse: done=%b act=%b required 0 0", burst_done, burst_active);
    end
  endtask

  task automatic test_fill();
    logic [31:0] exp_order [4];
    exp_order[0] = 32'h10; exp_order[1] = 32'h11;
    exp_order[2] = 32'h12; exp_order[3] = 32'h13;
    for (int i = 0; i < 4; i++) tick(mk(4'd1, 32'h10 + i, 2'b00, i == 3), 1, 0);
    checks++;
    if (occupancy !== 3'd4 || S_RREADY !== 1'b0) begin
      errors++;
      $display("FAIL fill_full: occ=%0d rdy=%b required 4 0", occupancy, S_RREADY);
    end
    tick(mk(4'd1, 32'h14, 2'b00, 1'b0), 1, 0);
    checks++;
    if (occupancy !== 3'd4) begin
      errors++;
      $display("FAIL fill_fifth_rejected: occ=%0d required 4", occupancy);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (M_RVALID !== 1'b1 || M_RDATA !== exp_order[i]) begin
        errors++;
        $display("FAIL fill_order[%0d]: vld=%b data=%h required 1 %h",
                 i, M_RVALID, M_RDATA, exp_order[i]);
      end
      // Keep offering the fifth beat on the first pop: it must not sneak in.
      tick(mk(4'd1, 32'h14, 2'b00, 1'b0), i == 0, 1);
      if (i == 0) begin
        checks++;
        if (S_RREADY !== 1'b1 || occupancy !== 3'd3) begin
          errors++;
          $display("FAIL fill_ready_after_pop: rdy=%b occ=%0d required 1 3", S_RREADY, occupancy);
        end
      end
    end
    checks++;
    if (occupancy !== 3'(mq.size()) || burst_done !== m_done) begin
      errors++;
      $display("FAIL fill_drained: occ=%0d done=%b required %0d %b",
               occupancy, burst_done, mq.size(), m_done);
    end
  endtask

  task automatic test_stream();
    int pulses = 0;
    int max_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (i < 8) begin
        checks++;
        if (S_RREADY !== 1'b1) begin
          errors++;
          $display("FAIL stream_ready[%0d]: rdy=%b required 1", i, S_RREADY);
        end
      end
      tick(mk(4'd5, 32'h100 + i, 2'b01, i == 7), i < 8, 1);
      checks++;
      if (beat_cnt !== 8'(m_cnt) || burst_active !== m_active || burst_done !== m_done) begin
        errors++;
        $display("FAIL stream_burst[%0d]: cnt=%0d act=%b done=%b required %0d %b %b",
                 i, beat_cnt, burst_active, burst_done, m_cnt, m_active, m_done);
      end
      if (burst_done === 1'b1) pulses++;
      if (int'(beat_cnt) > max_cnt) max_cnt = int'(beat_cnt);
    end
    checks++;
    if (pulses != 1 || max_cnt != 7 || beat_cnt !== 8'd0) begin
      errors++;
      $display("FAIL stream_summary: pulses=%0d max_cnt=%0d cnt=%0d required 1 7 0",
               pulses, max_cnt, beat_cnt);
    end
  endtask

  task automatic test_simul();
    tick(mk(4'd2, 32'h200, 2'b00, 1'b0), 1, 0);
    tick(mk(4'd2, 32'h201, 2'b00, 1'b0), 1, 0);
    for (int i = 0; i < 10; i++) begin
      tick(mk(4'd2, 32'h202 + i, 2'b00, i == 9), 1, 1);
      checks++;
      if (occupancy !== 3'd2 || M_RVALID !== 1'b1 || head_obs() !== mq[0]) begin
        errors++;
        $display("FAIL simul[%0d]: occ=%0d head=%h required 2 %h", i, occupancy, head_obs(), mq[0]);
      end
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (head_obs() !== mq[0]) begin
        errors++;
        $display("FAIL simul_drain[%0d]: head=%h required %h", i, head_obs(), mq[0]);
      end
      tick(mk(4'd0, 32'h0, 2'b00, 1'b0), 0, 1);
    end
  endtask

  task automatic test_stall();
    beat_t b;
    b = mk(4'd9, 32'hDEAD_BEEF, 2'b10, 1'b1);
    tick(b, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick(mk(4'd0, 32'h0, 2'b00, 1'b0), 0, 0);
      checks++;
      if (M_RVALID !== 1'b1 || head_obs() !== b || M_RRESP !== 2'b10) begin
        errors++;
        $display("FAIL stall[%0d]: vld=%b head=%h required 1 %h", i, M_RVALID, head_obs(), b);
      end
    end
    tick(mk(4'd0, 32'h0, 2'b00, 1'b0), 0, 1);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) tick(mk(4'd7, 32'h300 + i, 2'b00, i == 3), 1, 0);
    for (int i = 0; i < 2; i++) tick(mk(4'd0, 32'h0, 2'b00, 1'b0), 0, 1);
    checks++;
    if (burst_active !== 1'b1 || beat_cnt !== 8'd2) begin
      errors++;
      $display("FAIL reset_mid_pre: act=%b cnt=%0d required 1 2", burst_active, beat_cnt);
    end
    reset_tick();
    ARESETn = 1'b1;
    #1;
    checks++;
    if (occupancy !== 3'd0 || burst_active !== 1'b0 || beat_cnt !== 8'd0 ||
        burst_done !== 1'b0 || M_RVALID !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_post: occ=%0d act=%b cnt=%0d done=%b vld=%b required 0 0 0 0 0",
               occupancy, burst_active, beat_cnt, burst_done, M_RVALID);
    end
    @(negedge ACLK);
  endtask

  task automatic test_random();
    beat_t b;
    for (int i = 0; i < 400; i++) begin
      b = mk(4'($urandom), 32'($urandom), 2'($urandom), $urandom_range(0, 3) == 0);
      tick(b, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
      checks++;
      if (S_RREADY !== (mq.size() < DEPTH) || M_RVALID !== (mq.size() > 0) ||
          occupancy !== 3'(mq.size())) begin
        errors++;
        $display("FAIL random_fifo[%0d]: rdy=%b vld=%b occ=%0d required %b %b %0d", i,
                 S_RREADY, M_RVALID, occupancy, mq.size() < DEPTH, mq.size() > 0, mq.size());
      end
      checks++;
      if (beat_cnt !== 8'(m_cnt) || burst_active !== m_active || burst_done !== m_done) begin
        errors++;
        $display("FAIL random_burst[%0d]: cnt=%0d act=%b done=%b required %0d %b %b",
                 i, beat_cnt, burst_active, burst_done, m_cnt, m_active, m_done);
      end
      if (mq.size() > 0) begin
        checks++;
        if (head_obs() !== mq[0]) begin
          errors++;
          $display("FAIL random_head[%0d]: head=%h required %h", i, head_obs(), mq[0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_stream();
    test_simul();
    test_stall();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
